inj_scan_ctrl: RTL

Injection scan sequencer for the MONOPIX MIO firmware. It runs the pixel-scan loop in hardware, with no software handshake per step. Each step reloads the chip configuration through the SPI core, waits for the analog front end to settle, fires a burst of injection pulses, and opens a TDC gate window around each pulse. It sits in the CLK40 domain and drives the pulse_gen EXT_START input, the tdc_s3 EXT_EN input and the SPI start input.

---
 rtl/inj_scan_pkg.sv | 18 +
 rtl/inj_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inj_scan_pkg.sv
// Shared types and constants for the injection scan sequencer.
package inj_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONF,
        CONF_WAIT,
        SETTLE,
        INJ,
        INJ_WAIT,
        NEXT,
        FINISH
    } state_t;

    localparam int MIN_CONF_WAIT  = 4;
    localparam int MIN_INJ_PERIOD = 2;

endpackage

// File: rtl/inj_scan_ctrl.sv
// Hardware pixel-scan loop: per step SPI reload, settle wait, injection burst with TDC gate.
// Every output is a register loaded with the value that belongs to the next state.
module inj_scan_ctrl
    import inj_scan_pkg::*;
#(
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  CONF_EN,
    input  logic [STEP_WIDTH-1:0] N_STEPS,
    input  logic [CNT_WIDTH-1:0]  N_INJ,
    input  logic [CNT_WIDTH-1:0]  SETTLE_CYC,
    input  logic [CNT_WIDTH-1:0]  INJ_PERIOD,
    input  logic [CNT_WIDTH-1:0]  GATE_LEN,
    input  logic                  EN_GRAY_RST,
    input  logic                  SPI_READY,
    input  logic                  HOLD,
    output logic                  SPI_START,
    output logic                  INJ_START,
    output logic                  GATE,
    output logic                  GRAY_RST,
    output logic [STEP_WIDTH-1:0] STEP,
    output logic [CNT_WIDTH-1:0]  INJ_CNT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [CNT_WIDTH-1:0]  C_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  C_MIN_PER = CNT_WIDTH'(MIN_INJ_PERIOD);
    localparam logic [CNT_WIDTH-1:0]  C_CONF_LAST = CNT_WIDTH'(MIN_CONF_WAIT - 1);
    localparam logic [CNT_WIDTH:0]    W_ONE     = (CNT_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH:0]    W_TWO     = (CNT_WIDTH+1)'(2);
    localparam logic [STEP_WIDTH-1:0] S_ONE     = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH:0]   SW_ONE    = (STEP_WIDTH+1)'(1);

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    abort_pend;
    logic                    conf_en_q, gray_en_q;
    logic [STEP_WIDTH-1:0]   n_steps_q;
    logic [CNT_WIDTH-1:0]    n_inj_q, settle_q, period_q, gate_q;
    logic [CNT_WIDTH-1:0]    period_eff, gate_eff;

    // Period floor and gate clip are resolved once at START so the loop compares plain registers.
    always_comb begin
        period_eff = (INJ_PERIOD < C_MIN_PER) ? C_MIN_PER : INJ_PERIOD;
        gate_eff   = (GATE_LEN > period_eff - C_ONE) ? period_eff - C_ONE : GATE_LEN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            abort_pend <= 1'b0;
            conf_en_q  <= 1'b0;
            gray_en_q  <= 1'b0;
            n_steps_q  <= '0;
            n_inj_q    <= '0;
            settle_q   <= '0;
            period_q   <= '0;
            gate_q     <= '0;
            SPI_START  <= 1'b0;
            INJ_START  <= 1'b0;
            GATE       <= 1'b0;
            GRAY_RST   <= 1'b0;
            STEP       <= '0;
            INJ_CNT    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            SPI_START <= 1'b0;
            INJ_START <= 1'b0;
            GRAY_RST  <= 1'b0;
            if (state == IDLE) begin
                if (START) begin
                    conf_en_q  <= CONF_EN;
                    gray_en_q  <= EN_GRAY_RST;
                    n_steps_q  <= N_STEPS;
                    n_inj_q    <= N_INJ;
                    settle_q   <= SETTLE_CYC;
                    period_q   <= period_eff;
                    gate_q     <= gate_eff;
                    STEP       <= '0;
                    INJ_CNT    <= '0;
                    cnt        <= '0;
                    BUSY       <= 1'b1;
                    DONE       <= 1'b0;
                    // An ABORT coinciding with START is replayed in the first scan cycle.
                    abort_pend <= ABORT && (N_STEPS != '0);
                    if (N_STEPS == '0) begin
                        state <= FINISH;
                    end else begin
                        state     <= CONF_EN ? CONF : SETTLE;
                        SPI_START <= CONF_EN;
                        GRAY_RST  <= EN_GRAY_RST;
                    end
                end
            end else if ((ABORT || abort_pend) && state != FINISH) begin
                state      <= FINISH;
                GATE       <= 1'b0;
                cnt        <= '0;
                abort_pend <= 1'b0;
            end else begin
                case (state)
                    CONF: begin
                        state <= CONF_WAIT;
                        cnt   <= '0;
                    end
                    CONF_WAIT: begin
                        if (cnt >= C_CONF_LAST && SPI_READY) begin
                            state <= SETTLE;
                            cnt   <= '0;
                        end else if (cnt < C_CONF_LAST) begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    SETTLE: begin
                        if ({1'b0, cnt} + W_ONE >= {1'b0, settle_q}) begin
                            state <= (n_inj_q == '0) ? NEXT : INJ;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    INJ: begin
                        if (!HOLD) begin
                            state     <= INJ_WAIT;
                            INJ_START <= 1'b1;
                            GATE      <= (gate_q != '0);
                            INJ_CNT   <= INJ_CNT + C_ONE;
                            cnt       <= '0;
                        end
                    end
                    INJ_WAIT: begin
                        // The pulse cycle is cnt=0; the next INJ cycle completes the period.
                        GATE <= ({1'b0, cnt} + W_ONE < {1'b0, gate_q});
                        if ({1'b0, cnt} + W_TWO >= {1'b0, period_q}) begin
                            state <= (INJ_CNT < n_inj_q) ? INJ : NEXT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    NEXT: begin
                        INJ_CNT <= '0;
                        cnt     <= '0;
                        if ({1'b0, STEP} + SW_ONE == {1'b0, n_steps_q}) begin
                            state <= FINISH;
                        end else begin
                            STEP      <= STEP + S_ONE;
                            state     <= conf_en_q ? CONF : SETTLE;
                            SPI_START <= conf_en_q;
                            GRAY_RST  <= gray_en_q;
                        end
                    end
                    FINISH: begin
                        state      <= IDLE;
                        DONE       <= 1'b1;
                        BUSY       <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
